// File: rtl/dispatch_buffer_pkg.sv
// Shared types and defaults for the rename-to-dispatch buffer.
package dispatch_buffer_pkg;

    localparam int DISPATCH_BUF_DEPTH = 8;
    localparam int DISPATCH_ROB_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ALU    = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [4:0]  rd;
        logic [22:0] imm;
    } instruction_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/dispatch_buffer_if.sv
// Rename-side and Dispatch-side signals of the dispatch buffer; master is the buffer itself.
interface dispatch_buffer_if #(
    parameter int ROB_WIDTH = 4
);
    import dispatch_buffer_pkg::*;

    logic                 flush;
    logic [ROB_WIDTH-1:0] flush_rob_tail;
    logic [1:0]           in_valid;
    instruction_t         in_instruction_0;
    instruction_t         in_instruction_1;
    logic                 in_ready;
    logic [ROB_WIDTH:0]   rob_free_count;
    logic                 dispatch_ready;
    logic [1:0]           rename_valid;
    instruction_t         rename_instruction_0;
    instruction_t         rename_instruction_1;
    logic [ROB_WIDTH-1:0] rob_id_0;
    logic [ROB_WIDTH-1:0] rob_id_1;
    logic [1:0]           rob_alloc;

    modport master (
        input  flush, flush_rob_tail, in_valid, in_instruction_0, in_instruction_1,
               rob_free_count, dispatch_ready,
        output in_ready, rename_valid, rename_instruction_0, rename_instruction_1,
               rob_id_0, rob_id_1, rob_alloc
    );

    modport slave (
        output flush, flush_rob_tail, in_valid, in_instruction_0, in_instruction_1,
               rob_free_count, dispatch_ready,
        input  in_ready, rename_valid, rename_instruction_0, rename_instruction_1,
               rob_id_0, rob_id_1, rob_alloc
    );

endinterface

// File: rtl/dispatch_buffer_ptr.sv
// Head/tail/count and ROB tail bookkeeping for the dispatch buffer; pointers wrap modulo DEPTH.
module dispatch_buffer_ptr
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH     = DISPATCH_BUF_DEPTH,
    parameter int ROB_WIDTH = DISPATCH_ROB_WIDTH,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [ROB_WIDTH-1:0] flush_rob_tail_i,
    input  logic [1:0]           push_mask_i,
    input  logic [1:0]           pop_mask_i,
    output logic [AW-1:0]        head_o,
    output logic [AW-1:0]        tail_o,
    output logic [CW-1:0]        count_o,
    output logic [ROB_WIDTH-1:0] rob_tail_o
);

    logic [AW-1:0]        head_q, head_d;
    logic [AW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [ROB_WIDTH-1:0] rob_tail_q, rob_tail_d;
    logic [1:0]           push_n, pop_n;

    assign push_n = popcount2(push_mask_i);
    assign pop_n  = popcount2(pop_mask_i);

    always_comb begin
        head_d     = head_q + AW'(pop_n);
        tail_d     = tail_q + AW'(push_n);
        count_d    = count_q + CW'(push_n) - CW'(pop_n);
        rob_tail_d = rob_tail_q + ROB_WIDTH'(pop_n);
        // A flush discards every queued entry and restarts ROB allocation where the ROB says.
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            rob_tail_d = flush_rob_tail_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rob_tail_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rob_tail_q <= rob_tail_d;
        end
    end

    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign count_o    = count_q;
    assign rob_tail_o = rob_tail_q;

endmodule

// File: rtl/dispatch_buffer.sv
// In-order 2-wide queue between rename and Dispatch; allocates ROB ids from a circular tail.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH     = DISPATCH_BUF_DEPTH,
    parameter int ROB_WIDTH = DISPATCH_ROB_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    dispatch_buffer_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    instruction_t         mem_q [DEPTH];
    logic [AW-1:0]        head_q, tail_q, head_p1, tail_p1;
    logic [CW-1:0]        count_q;
    logic [ROB_WIDTH-1:0] rob_tail_q;
    logic                 active, accept;
    logic [1:0]           avail, rv, alloc, push_mask;

    dispatch_buffer_ptr #(
        .DEPTH     (DEPTH),
        .ROB_WIDTH (ROB_WIDTH)
    ) u_ptr (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (bus.flush),
        .flush_rob_tail_i (bus.flush_rob_tail),
        .push_mask_i      (push_mask),
        .pop_mask_i       (alloc),
        .head_o           (head_q),
        .tail_o           (tail_q),
        .count_o          (count_q),
        .rob_tail_o       (rob_tail_q)
    );

    assign active    = !rst && !bus.flush;
    assign accept    = active && (count_q <= CW'(DEPTH - 2));
    assign push_mask = accept ? bus.in_valid : 2'b00;
    assign head_p1   = head_q + AW'(1);
    assign tail_p1   = tail_q + AW'(1);

    // Presentable entries are bounded by occupancy and by the ROB slots still free.
    always_comb begin
        avail = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        if (bus.rob_free_count < (ROB_WIDTH + 1)'(avail)) begin
            avail = bus.rob_free_count[1:0];
        end
        rv    = active ? {avail[1], |avail} : 2'b00;
        alloc = (active && bus.dispatch_ready) ? rv : 2'b00;
    end

    always_comb begin
        bus.in_ready             = accept;
        bus.rename_valid         = rv;
        bus.rob_alloc            = alloc;
        bus.rename_instruction_0 = active ? mem_q[head_q]  : '0;
        bus.rename_instruction_1 = active ? mem_q[head_p1] : '0;
        bus.rob_id_0             = active ? rob_tail_q : '0;
        bus.rob_id_1             = active ? rob_tail_q + ROB_WIDTH'(1) : '0;
    end

    // Storage is data only; pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (bus.in_valid)
                2'b11: begin
                    mem_q[tail_q]  <= bus.in_instruction_0;
                    mem_q[tail_p1] <= bus.in_instruction_1;
                end
                2'b01:   mem_q[tail_q] <= bus.in_instruction_0;
                2'b10:   mem_q[tail_q] <= bus.in_instruction_1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: stimulus queues expectations, a negedge monitor checks them.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int S_RDY   = 0;
    localparam int S_RV    = 1;
    localparam int S_ALLOC = 2;
    localparam int S_ID0   = 3;
    localparam int S_ID1   = 4;
    localparam int S_INS0  = 5;
    localparam int S_SB    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dispatch_buffer_if #(.ROB_WIDTH(4)) bus();

    dispatch_buffer #(
        .DEPTH     (8),
        .ROB_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        instruction_t ins;
        logic [3:0]   rid;
    } sb_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    sb_t  sb [$];
    chk_t chk_q [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   seq = 1;
    logic [3:0] next_rob = '0;

    function automatic instruction_t mk(input int s);
        instruction_t t;
        t.opcode = OP_ALU;
        t.rd     = 5'(s);
        t.imm    = 23'(s);
        return t;
    endfunction

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            S_RDY:   return 32'(bus.in_ready);
            S_RV:    return 32'(bus.rename_valid);
            S_ALLOC: return 32'(bus.rob_alloc);
            S_ID0:   return 32'(bus.rob_id_0);
            S_ID1:   return 32'(bus.rob_id_1);
            S_INS0:  return bus.rename_instruction_0;
            S_SB:    return 32'(sb.size());
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic want(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and record what the buffer is expected to accept.
    task automatic drive(input logic r, input logic [1:0] v, input logic dr, input logic fl,
                         input logic [4:0] free, input logic [3:0] frt);
        sb_t e;
        rst                  = r;
        bus.in_valid         = v;
        bus.dispatch_ready   = dr;
        bus.flush            = fl;
        bus.rob_free_count   = free;
        bus.flush_rob_tail   = frt;
        bus.in_instruction_0 = mk(seq);
        bus.in_instruction_1 = mk(seq + 1);
        #1;
        if (r) begin
            sb.delete();
            next_rob = '0;
        end else if (fl) begin
            sb.delete();
            next_rob = frt;
        end else if (bus.in_ready) begin
            if (v[0]) begin
                e.ins = mk(seq); e.rid = next_rob; sb.push_back(e); next_rob++;
            end
            if (v[1]) begin
                e.ins = mk(seq + 1); e.rid = next_rob; sb.push_back(e); next_rob++;
            end
        end
        seq += 2;
    endtask

    chk_t         mc;
    sb_t          me;
    logic [31:0]  mact;
    instruction_t mins;
    logic [3:0]   mid;

    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            mc   = chk_q.pop_front();
            mact = sig(mc.sel);
            n_vec++;
            if (mact !== mc.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h, want 0x%0h", mc.name, mact, mc.exp);
            end
        end
        if (bus.rob_alloc != 2'b00) begin
            n_vec++;
            if (bus.rob_alloc == 2'b10 || bus.rob_alloc !== bus.rename_valid) begin
                n_err++;
                $display("FAIL alloc_shape: got alloc %b valid %b, want alloc==valid and not 10",
                         bus.rob_alloc, bus.rename_valid);
            end
            for (int k = 0; k < 2; k++) begin
                if (bus.rob_alloc[k]) begin
                    n_vec++;
                    mins = (k == 0) ? bus.rename_instruction_0 : bus.rename_instruction_1;
                    mid  = (k == 0) ? bus.rob_id_0 : bus.rob_id_1;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL dispatch%0d: got ins 0x%0h id %0d, want no dispatch", k, mins, mid);
                    end else begin
                        me = sb.pop_front();
                        if (mins !== me.ins || mid !== me.rid) begin
                            n_err++;
                            $display("FAIL dispatch%0d: got ins 0x%0h id %0d, want ins 0x%0h id %0d",
                                     k, mins, mid, me.ins, me.rid);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid         = 2'b00;
        bus.dispatch_ready   = 1'b0;
        bus.flush            = 1'b0;
        bus.rob_free_count   = 5'd16;
        bus.flush_rob_tail   = '0;
        bus.in_instruction_0 = '0;
        bus.in_instruction_1 = '0;
        tick();

        // Reset cycle: nothing accepted or presented.
        drive(1'b1, 2'b11, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RDY, 0, "rst_in_ready"); want(S_RV, 0, "rst_valid"); want(S_ALLOC, 0, "rst_alloc");
        tick();

        // Fill without dispatch: ready drops once count reaches 8.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0);
            want(S_RDY, (i < 4) ? 1 : 0, "fill_in_ready");
            want(S_RV, (i == 0) ? 0 : 3, "fill_valid");
            want(S_ALLOC, 0, "fill_alloc");
            tick();
        end

        // Drain two per cycle: id pairs 0/1, 2/3, 4/5, 6/7.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
            want(S_RV, 3, "drain_valid"); want(S_ALLOC, 3, "drain_alloc");
            want(S_ID0, 2 * i, "drain_id0"); want(S_ID1, 2 * i + 1, "drain_id1");
            tick();
        end
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RV, 0, "empty_valid"); want(S_ALLOC, 0, "empty_alloc"); want(S_SB, 0, "empty_sb");
        tick();

        // ROB space limits: one free slot lets only the head go, zero lets none.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b01, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd1, 4'd0);
        want(S_RV, 1, "rob1_valid"); want(S_ALLOC, 1, "rob1_alloc"); want(S_ID0, 8, "rob1_id0");
        tick();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 4'd0);
        want(S_RV, 0, "rob0_valid"); want(S_ALLOC, 0, "rob0_alloc");
        tick();

        // Simultaneous push of inst1 only and pop of two.
        drive(1'b0, 2'b10, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RDY, 1, "pp_in_ready"); want(S_RV, 3, "pp_valid");
        want(S_ID0, 9, "pp_id0"); want(S_ID1, 10, "pp_id1");
        tick();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RV, 1, "pp_tail_valid"); want(S_ALLOC, 1, "pp_tail_alloc"); want(S_ID0, 11, "pp_tail_id0");
        tick();

        // Streaming 20 instructions across the pointer and ROB-id wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'b11, 1'b1, 1'b0, 5'd16, 4'd0);
            if (i > 0) want(S_RV, 3, "wrap_valid");
            if (i == 2) begin want(S_ID0, 14, "wrap_id14"); want(S_ID1, 15, "wrap_id15"); end
            if (i == 3) begin want(S_ID0, 0, "wrap_id0"); want(S_ID1, 1, "wrap_id1"); end
            tick();
        end
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RV, 3, "wrap_last_valid"); want(S_ALLOC, 3, "wrap_last_alloc");
        tick();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RV, 0, "wrap_empty_valid"); want(S_SB, 0, "wrap_empty_sb");
        tick();

        // Flush with five entries queued, resuming ROB allocation at 9.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b01, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 5'd16, 4'd9);
        want(S_RDY, 0, "flush_in_ready"); want(S_RV, 0, "flush_valid");
        want(S_ALLOC, 0, "flush_alloc"); want(S_INS0, 0, "flush_ins0");
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd16, 4'd0);
        want(S_RV, 0, "post_flush_valid"); want(S_RDY, 1, "post_flush_in_ready");
        tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RV, 3, "resume_valid"); want(S_ALLOC, 3, "resume_alloc");
        want(S_ID0, 9, "resume_id0"); want(S_ID1, 10, "resume_id1");
        tick();

        // Reset in the middle of a fill drops everything.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b1, 2'b11, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RDY, 0, "midrst_in_ready"); want(S_RV, 0, "midrst_valid");
        want(S_ALLOC, 0, "midrst_alloc"); want(S_ID0, 0, "midrst_id0");
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd16, 4'd0);
        want(S_RV, 0, "after_rst_valid"); want(S_RDY, 1, "after_rst_in_ready");
        tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd16, 4'd0); tick();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 5'd16, 4'd0);
        want(S_RV, 3, "after_rst_disp_valid");
        want(S_ID0, 0, "after_rst_id0"); want(S_ID1, 1, "after_rst_id1");
        tick();

        drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd16, 4'd0);
        want(S_SB, 0, "final_sb");
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
